// File: rtl/mem_access.sv
// mem_access: RV32I memory-access stage (EX/MEM -> WB) with data-bus request/grant/response.
//
// Ports:
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   valid_i, operation_i   EX/MEM slot valid and decoded operation
//   mem_addr_i             effective address (rs1+imm)
//   mem_wr_data_i          store data (rs2)
//   rd_data_i              ALU result for non-memory ops
//   rf_wr_enable_i         register write request from execute
//   rd_addr_i              destination register
//   stall_o                stage busy; upstream holds and valid_i is ignored
//   dbus_req_o/we_o/addr_o/be_o/wdata_o   data-bus request (nonzero only in REQ)
//   dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i   data-bus grant and read response
//   wb_valid_o             one-cycle write-back pulse
//   wb_rd_addr_o, wb_rd_data_o, wb_rf_wr_enable_o   registered write-back bundle
//   misalign_o             misaligned-access pulse
//
// Build option: define MISALIGN_TRAP_EN to report misaligned half/word accesses
// through misalign_o instead of silently forcing natural alignment.

typedef enum logic [5:0] {
    UNKNOWN, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
} operation_e;

module mem_access #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  operation_e      operation_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wr_data_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rf_wr_enable_i,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_rd_data_o,
    output logic            wb_rf_wr_enable_o,
    output logic            misalign_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    function automatic logic is_load(input operation_e op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store(input operation_e op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic is_byte(input operation_e op);
        return op inside {LB, LBU, SB};
    endfunction

    function automatic logic is_half(input operation_e op);
        return op inside {LH, LHU, SH};
    endfunction

    function automatic logic is_word(input operation_e op);
        return op inside {LW, SW};
    endfunction

    state_e          state_q, state_d;
    operation_e      op_q, op_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_we_q, wb_we_d;
    logic            misalign_q, misalign_d;

    logic            in_mem;
    logic            trap;
    logic [XLEN-1:0] in_addr;
    logic            in_req;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] store_wdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign in_mem = is_load(operation_i) || is_store(operation_i);

`ifdef MISALIGN_TRAP_EN
    logic in_misaligned;
    assign in_misaligned = (is_half(operation_i) && mem_addr_i[0]) ||
                           (is_word(operation_i) && (mem_addr_i[1:0] != 2'b00));
    assign trap = in_mem && in_misaligned;
`else
    assign trap = 1'b0;
`endif

    // Natural alignment is forced on capture; with the trap enabled a
    // misaligned access never gets captured, so this is then a no-op.
    assign in_addr = is_half(operation_i) ? {mem_addr_i[XLEN-1:1], 1'b0} :
                     is_word(operation_i) ? {mem_addr_i[XLEN-1:2], 2'b00} : mem_addr_i;

    assign lane_be     = is_byte(op_q) ? 4'b0001 << addr_q[1:0] :
                         is_half(op_q) ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign store_wdata = is_byte(op_q) ? {4{wdata_q[7:0]}} :
                         is_half(op_q) ? {2{wdata_q[15:0]}} : wdata_q;

    assign ld_byte = addr_q[1] ? (addr_q[0] ? dbus_rdata_i[31:24] : dbus_rdata_i[23:16])
                               : (addr_q[0] ? dbus_rdata_i[15:8]  : dbus_rdata_i[7:0]);
    assign ld_half = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    assign ld_data = (op_q == LB)  ? {{24{ld_byte[7]}}, ld_byte} :
                     (op_q == LBU) ? {24'b0, ld_byte} :
                     (op_q == LH)  ? {{16{ld_half[15]}}, ld_half} :
                     (op_q == LHU) ? {16'b0, ld_half} : dbus_rdata_i;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        misalign_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (trap) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = rd_addr_i;
                        wb_data_d  = mem_addr_i;
                    end else if (in_mem) begin
                        state_d = REQ;
                        op_d    = operation_i;
                        addr_d  = in_addr;
                        wdata_d = mem_wr_data_i;
                        rd_d    = rd_addr_i;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = rf_wr_enable_i;
                        wb_rd_d    = rd_addr_i;
                        wb_data_d  = rd_data_i;
                    end
                end
            end
            REQ: begin
                if (dbus_gnt_i) begin
                    if (is_store(op_q)) begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = rd_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dbus_rvalid_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            op_q       <= UNKNOWN;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
            misalign_q <= misalign_d;
        end
    end

    // Bus outputs decode straight from state so an async reset drops them at once.
    assign in_req       = (state_q == REQ);
    assign stall_o      = (state_q != IDLE);
    assign dbus_req_o   = in_req;
    assign dbus_we_o    = in_req && is_store(op_q);
    assign dbus_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dbus_be_o    = in_req ? lane_be : 4'b0000;
    assign dbus_wdata_o = (in_req && is_store(op_q)) ? store_wdata : '0;

    assign wb_valid_o        = wb_valid_q;
    assign wb_rd_addr_o      = wb_rd_q;
    assign wb_rd_data_o      = wb_data_q;
    assign wb_rf_wr_enable_o = wb_we_q;
    assign misalign_o        = misalign_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access (write-back and bus-request queues).
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0;
    operation_e  operation_i = ADD;
    logic [31:0] mem_addr_i = '0, mem_wr_data_i = '0, rd_data_i = '0;
    logic        rf_wr_enable_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        stall_o, dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i = 1'b0, dbus_rvalid_i = 1'b0;
    logic [31:0] dbus_rdata_i = '0;
    logic        wb_valid_o, wb_rf_wr_enable_o, misalign_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;

    mem_access dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .operation_i(operation_i),
        .mem_addr_i(mem_addr_i), .mem_wr_data_i(mem_wr_data_i), .rd_data_i(rd_data_i),
        .rf_wr_enable_i(rf_wr_enable_i), .rd_addr_i(rd_addr_i), .stall_o(stall_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_data_o(wb_rd_data_o),
        .wb_rf_wr_enable_o(wb_rf_wr_enable_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        logic        chk_data;
    } wb_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    wb_t  wb_e;
    bus_t bus_e;
    int   checks = 0, failures = 0, stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (stall_o) stall_cnt++;
        if (wb_valid_o) begin
            if (wb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: pulse rd=%0d data=%h, no pulse required (cycle %0d)",
                         wb_rd_addr_o, wb_rd_data_o, cyc);
            end else begin
                wb_e = wb_q.pop_front();
                chk("wb_cycle", cyc, wb_e.cyc);
                chk("wb_we", {31'b0, wb_rf_wr_enable_o}, {31'b0, wb_e.we});
                chk("wb_misalign", {31'b0, misalign_o}, {31'b0, wb_e.mis});
                if (wb_e.chk_data) begin
                    chk("wb_data", wb_rd_data_o, wb_e.data);
                    chk("wb_rd", {27'b0, wb_rd_addr_o}, {27'b0, wb_e.rd});
                end
            end
        end
        if (dbus_req_o && dbus_gnt_i) begin
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected: granted request addr=%h, no request required", dbus_addr_o);
            end else begin
                bus_e = bus_q.pop_front();
                chk("bus_we", {31'b0, dbus_we_o}, {31'b0, bus_e.we});
                chk("bus_addr", dbus_addr_o, bus_e.addr);
                chk("bus_be", {28'b0, dbus_be_o}, {28'b0, bus_e.be});
                chk("bus_wdata", dbus_wdata_o, bus_e.wdata);
            end
        end
    end

    task automatic push_wb(input int lat, input logic [31:0] d, input logic [4:0] rd,
                           input logic we, input logic mis, input logic cd);
        wb_t e;
        e.cyc = cyc + lat; e.data = d; e.rd = rd; e.we = we; e.mis = mis; e.chk_data = cd;
        wb_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd);
        bus_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    task automatic drive(input operation_e op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdd, input logic we, input logic [4:0] rd);
        valid_i = 1'b1; operation_i = op; mem_addr_i = a; mem_wr_data_i = wd;
        rd_data_i = rdd; rf_wr_enable_i = we; rd_addr_i = rd;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic alu(input operation_e op, input logic [31:0] rdd, input logic we,
                       input logic [4:0] rd);
        push_wb(1, rdd, rd, we, 1'b0, 1'b1);
        drive(op, 32'h0, 32'h0, rdd, we, rd);
    endtask

    task automatic store(input operation_e op, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input logic [31:0] ea, input logic [3:0] be,
                         input logic [31:0] ewd);
        push_bus(1'b1, ea, be, ewd);
        push_wb(2 + gd, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(op, a, wd, 32'hFFFF_FFFF, 1'b1, 5'd31);
        repeat (gd) begin @(posedge clk); #1; end
        dbus_gnt_i = 1'b1;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
    endtask

    task automatic load(input operation_e op, input logic [31:0] a, input logic [31:0] rdat,
                        input logic [4:0] rd, input logic [31:0] ea, input logic [3:0] be,
                        input logic [31:0] ed);
        push_bus(1'b0, ea, be, 32'h0);
        push_wb(3, ed, rd, 1'b1, 1'b0, 1'b1);
        drive(op, a, 32'h5555_AAAA, 32'h0, 1'b1, rd);
        dbus_gnt_i = 1'b1;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
        chk("wait_req", {31'b0, dbus_req_o}, 32'h0);
        chk("wait_addr", dbus_addr_o, 32'h0);
        dbus_rvalid_i = 1'b1; dbus_rdata_i = rdat;
        @(posedge clk); #1;
        dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_stall"}, {31'b0, stall_o}, 32'h0);
        chk({tag, "_req"}, {31'b0, dbus_req_o}, 32'h0);
        chk({tag, "_addr"}, dbus_addr_o, 32'h0);
        chk({tag, "_be"}, {28'b0, dbus_be_o}, 32'h0);
        chk({tag, "_wdata"}, dbus_wdata_o, 32'h0);
        chk({tag, "_wbv"}, {31'b0, wb_valid_o}, 32'h0);
        chk({tag, "_wbdata"}, wb_rd_data_o, 32'h0);
        chk({tag, "_wbrd"}, {27'b0, wb_rd_addr_o}, 32'h0);
        chk({tag, "_wbwe"}, {31'b0, wb_rf_wr_enable_o}, 32'h0);
        chk({tag, "_mis"}, {31'b0, misalign_o}, 32'h0);
    endtask

    initial begin
        #12;
        chk_idle_zero("reset");
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;

        stall_cnt = 0;
        alu(ADD, 32'h0000_1234, 1'b1, 5'd5);
        @(negedge clk); #1;
        chk("add_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        alu(UNKNOWN, 32'hDEAD_BEEF, 1'b0, 5'd3);

        stall_cnt = 0;
        store(SB, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        chk("sb_stall_cnt", stall_cnt, 32'd3);
        store(SH, 32'h0000_0102, 32'h1234_BEEF, 0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);
        store(SW, 32'h0000_0204, 32'hCAFE_F00D, 1, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D);

        load(LB,  32'h0000_0102, 32'h0080_FF00, 5'd7,  32'h0000_0100, 4'b0100, 32'hFFFF_FF80);
        load(LBU, 32'h0000_0102, 32'h0080_FF00, 5'd8,  32'h0000_0100, 4'b0100, 32'h0000_0080);
        load(LH,  32'h0000_0102, 32'h0080_FF00, 5'd9,  32'h0000_0100, 4'b1100, 32'h0000_0080);
        load(LH,  32'h0000_0100, 32'h0080_FF00, 5'd10, 32'h0000_0100, 4'b0011, 32'hFFFF_FF00);
        load(LHU, 32'h0000_0100, 32'h0080_FF00, 5'd11, 32'h0000_0100, 4'b0011, 32'h0000_FF00);
        load(LW,  32'h0000_0108, 32'h89AB_CDEF, 5'd12, 32'h0000_0108, 4'b1111, 32'h89AB_CDEF);
        alu(SUB, 32'h0000_0042, 1'b1, 5'd13);

`ifdef MISALIGN_TRAP_EN
        push_wb(1, 32'h0000_0101, 5'd14, 1'b0, 1'b1, 1'b1);
        drive(LW, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 5'd14);
        chk("mis_lw_req", {31'b0, dbus_req_o}, 32'h0);
        chk("mis_lw_stall", {31'b0, stall_o}, 32'h0);
        push_wb(1, 32'h0000_0103, 5'd15, 1'b0, 1'b1, 1'b1);
        drive(SH, 32'h0000_0103, 32'h0000_ABCD, 32'h0, 1'b1, 5'd15);
        chk("mis_sh_req", {31'b0, dbus_req_o}, 32'h0);
`else
        load(LW, 32'h0000_0101, 32'h1122_3344, 5'd14, 32'h0000_0100, 4'b1111, 32'h1122_3344);
        store(SH, 32'h0000_0103, 32'h0000_ABCD, 0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
`endif

        push_bus(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
        drive(LW, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 5'd16);
        dbus_gnt_i = 1'b1;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        chk_idle_zero("rst_wait");
        @(posedge clk); #1;
        rstn_i = 1'b1;
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h7777_7777;
        @(posedge clk); #1;
        dbus_rvalid_i = 1'b0;
        chk_idle_zero("rst_late_rvalid");

        drive(LW, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 5'd17);
        chk("rst_req_before", {31'b0, dbus_req_o}, 32'h1);
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_req_drop", {31'b0, dbus_req_o}, 32'h0);
        chk("rst_req_addr", dbus_addr_o, 32'h0);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        dbus_rvalid_i = 1'b1;
        @(posedge clk); #1;
        dbus_rvalid_i = 1'b0;
        chk_idle_zero("rst_req_after");

        alu(ADD, 32'h0000_0099, 1'b1, 5'd18);
        repeat (4) @(posedge clk);
        #1;
        chk("wb_queue_empty", wb_q.size(), 32'd0);
        chk("bus_queue_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
